// File: rtl/fft64_bin_if.sv
// ---------------------------------------------------------------------------
// fft64_bin_if
// Valid/ready stream carrying one DFT bin per handshake.
//   out_valid  master->slave  a bin is presented
//   out_ready  slave->master  consumer accepts the bin
//   out_real   master->slave  real part, W bits, two's complement
//   out_imag   master->slave  imaginary part, W bits, two's complement
//   out_index  master->slave  bin index 0..63
//   out_last   master->slave  high with bin 63
//   out_mag    master->slave  |re|+|im|, W+1 bits (0 when magnitude disabled)
// ---------------------------------------------------------------------------
interface fft64_bin_if #(
    parameter int W = 16
) ();
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_real;
    logic [W-1:0] out_imag;
    logic [5:0]   out_index;
    logic         out_last;
    logic [W:0]   out_mag;

    modport master (
        output out_valid, out_real, out_imag, out_index, out_last, out_mag,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_index, out_last, out_mag,
        output out_ready
    );
endinterface

// File: rtl/fft64_bin_streamer.sv
// ---------------------------------------------------------------------------
// fft64_bin_streamer
// Captures the 8x8 real/imag DFT result on the one-cycle done pulse into a
// private snapshot, then streams the 64 bins out over a valid/ready interface
// so the DFT can start on the next frame while this one drains.
//
// Ports:
//   clk      rising-edge clock
//   sreset   synchronous active-high reset
//   done     frame-complete pulse from the DFT
//   realfft  real result array [row][col], sampled only when done=1
//   imagfft  imaginary result array [row][col], sampled only when done=1
//   out_if   bin stream (master side of fft64_bin_if)
//   busy     a frame is held or streaming
//   overrun  one-cycle pulse when an incoming frame is dropped
//
// Build option: define FFT64_BIN_MAG_EN to generate the L1 magnitude
// (|re|+|im|) on out_mag; otherwise out_mag is tied to 0.
// ---------------------------------------------------------------------------
module fft64_bin_streamer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         sreset,
    input  logic         done,
    input  logic [W-1:0] realfft [0:7][0:7],
    input  logic [W-1:0] imagfft [0:7][0:7],
    fft64_bin_if.master  out_if,
    output logic         busy,
    output logic         overrun
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [5:0]   index_q, index_d;
    logic         overrun_q, overrun_d;

    logic [W-1:0] snap_re_q [64];
    logic [W-1:0] snap_im_q [64];

    logic         streaming;
    logic         handshake;
    logic         final_beat;
    logic         capture;

    assign streaming  = (state_q == STREAM);
    assign handshake  = streaming && out_if.out_ready;
    assign final_beat = handshake && (index_q == 6'd63);
    // A new frame is taken when idle, or exactly on the last handshake so
    // consecutive frames stream without a bubble.
    assign capture    = done && !sreset && (!streaming || final_beat);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        index_d   = index_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (done) begin
                    state_d = STREAM;
                    index_d = 6'd0;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (index_q == 6'd63) begin
                        state_d = done ? STREAM : IDLE;
                        index_d = 6'd0;
                    end else begin
                        index_d = index_q + 6'd1;
                    end
                end
                // done at any time other than the last handshake is dropped.
                if (done && !final_beat) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = 6'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q   <= IDLE;
            index_q   <= 6'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef FFT64_BIN_MAG_EN
    logic [W:0] snap_mag_q [64];

    // Sign-extend to W+1 bits before negating so |-2^(W-1)| is representable.
    function automatic logic [W:0] abs_ext(input logic [W-1:0] v);
        logic [W:0] e;
        e = {v[W-1], v};
        return e[W] ? -e : e;
    endfunction
`endif

    // NOTE: the snapshot is plain storage with no reset; its contents are
    // only observable after a capture overwrites every entry.
    for (genvar b = 0; b < 64; b++) begin : g_snap
        always_ff @(posedge clk) begin
            if (capture) begin
                snap_re_q[b] <= realfft[b / 8][b % 8];
                snap_im_q[b] <= imagfft[b / 8][b % 8];
`ifdef FFT64_BIN_MAG_EN
                snap_mag_q[b] <= abs_ext(realfft[b / 8][b % 8])
                               + abs_ext(imagfft[b / 8][b % 8]);
`endif
            end
        end
    end

    // Outputs are decoded from registered state only; gating with the state
    // forces them to zero whenever idle, including right after reset.
    assign out_if.out_valid = streaming;
    assign out_if.out_real  = streaming ? snap_re_q[index_q] : '0;
    assign out_if.out_imag  = streaming ? snap_im_q[index_q] : '0;
    assign out_if.out_index = streaming ? index_q : 6'd0;
    assign out_if.out_last  = streaming && (index_q == 6'd63);
`ifdef FFT64_BIN_MAG_EN
    assign out_if.out_mag   = streaming ? snap_mag_q[index_q] : '0;
`else
    assign out_if.out_mag   = '0;
`endif
    assign busy    = streaming;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_fft64_bin_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft64_bin_streamer
// Directed bench for fft64_bin_streamer: reset values, full drain,
// backpressure, back-to-back frames, overrun, mid-stream reset, magnitude.
// ---------------------------------------------------------------------------
module tb_fft64_bin_streamer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         sreset;
    logic         done;
    logic [W-1:0] re_a [0:7][0:7];
    logic [W-1:0] im_a [0:7][0:7];
    logic         busy;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    fft64_bin_if #(.W(W)) s_if ();

    fft64_bin_streamer #(.W(W)) dut (
        .clk     (clk),
        .sreset  (sreset),
        .done    (done),
        .realfft (re_a),
        .imagfft (im_a),
        .out_if  (s_if),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Frame contents by kind; the bench's own reference for every bin.
    function automatic logic [W-1:0] g_re(input int k, input int i);
        case (k)
            0:       return 16'(i);
            1:       return 16'(100 + i);
            2:       return 16'(32'h1000 + i);
            3:       return 16'h7777;
            default: return (i == 0) ? 16'h8000 : (i == 1) ? 16'hFFFD : 16'(i);
        endcase
    endfunction

    function automatic logic [W-1:0] g_im(input int k, input int i);
        case (k)
            0:       return 16'(-i);
            1:       return 16'(3 * i);
            2:       return 16'(32'h2000 - i);
            3:       return 16'h1234;
            default: return (i == 0) ? 16'h7FFF : (i == 1) ? 16'h0004 : 16'(-i);
        endcase
    endfunction

    function automatic logic [W:0] mag_of(input logic [W-1:0] r, input logic [W-1:0] m);
`ifdef FFT64_BIN_MAG_EN
        int a;
        int b;
        a = int'($signed(r));
        b = int'($signed(m));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return 17'(a + b);
`else
        return 17'd0;
`endif
    endfunction

    task automatic load(input int k);
        for (int i = 0; i < 64; i++) begin
            re_a[i / 8][i % 8] = g_re(k, i);
            im_a[i / 8][i % 8] = g_im(k, i);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},   32'(s_if.out_valid), 32'd0);
        check({tag, "_real"},    32'(s_if.out_real),  32'd0);
        check({tag, "_imag"},    32'(s_if.out_imag),  32'd0);
        check({tag, "_index"},   32'(s_if.out_index), 32'd0);
        check({tag, "_last"},    32'(s_if.out_last),  32'd0);
        check({tag, "_mag"},     32'(s_if.out_mag),   32'd0);
        check({tag, "_busy"},    32'(busy),           32'd0);
        check({tag, "_overrun"}, 32'(overrun),        32'd0);
    endtask

    task automatic check_beat(input int k, input int i, input logic ovr);
        check($sformatf("valid[%0d]", i), 32'(s_if.out_valid), 32'd1);
        check($sformatf("real[%0d]", i),  32'(s_if.out_real),  32'(g_re(k, i)));
        check($sformatf("imag[%0d]", i),  32'(s_if.out_imag),  32'(g_im(k, i)));
        check($sformatf("index[%0d]", i), 32'(s_if.out_index), 32'(i));
        check($sformatf("last[%0d]", i),  32'(s_if.out_last),  32'(i == 63));
        check($sformatf("mag[%0d]", i),   32'(s_if.out_mag),   32'(mag_of(g_re(k, i), g_im(k, i))));
        check($sformatf("busy[%0d]", i),  32'(busy),           32'd1);
        check($sformatf("ovr[%0d]", i),   32'(overrun),        32'(ovr));
    endtask

    initial begin
        int          e;
        logic [15:0] lfsr;

        // Reset, with done high to confirm it is ignored.
        sreset = 1'b1;
        done   = 1'b1;
        s_if.out_ready = 1'b0;
        load(0);
        @(negedge clk);
        step();
        check_idle("rst");
        sreset = 1'b0;
        done   = 1'b0;
        step();
        check_idle("post_rst");

        // Basic drain with out_ready held high.
        load(0);
        done = 1'b1;
        s_if.out_ready = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check_beat(0, i, 1'b0);
            step();
        end
        check_idle("drain_end");

        // Backpressure from a fixed LFSR pattern.
        load(1);
        done = 1'b1;
        s_if.out_ready = 1'b0;
        step();
        done = 1'b0;
        e    = 0;
        lfsr = 16'hACE1;
        for (int cyc = 0; cyc < 600 && e < 64; cyc++) begin
            s_if.out_ready = lfsr[0];
            check_beat(1, e, 1'b0);
            step();
            if (lfsr[0]) e++;
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
        check("bp_delivered", 32'(e), 32'd64);
        s_if.out_ready = 1'b1;
        check_idle("bp_end");

        // Back-to-back: frame B captured on bin 63 handshake of frame A.
        load(0);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check_beat(0, i, 1'b0);
            if (i == 63) begin
                load(2);
                done = 1'b1;
            end
            step();
            done = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            check_beat(2, i, 1'b0);
            step();
        end
        check_idle("b2b_end");

        // Overrun: done while bin 10 is presented.
        load(0);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check_beat(0, i, (i == 11));
            if (i == 10) begin
                load(3);
                done = 1'b1;
            end
            step();
            done = 1'b0;
        end
        check_idle("ovr_end");

        // Reset at bin 30, done during reset ignored, then restart.
        load(1);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 31; i++) begin
            check_beat(1, i, 1'b0);
            if (i == 30) begin
                sreset = 1'b1;
                done   = 1'b1;
            end
            step();
        end
        sreset = 1'b0;
        done   = 1'b0;
        check_idle("mid_rst");
        step();
        check_idle("mid_rst_hold");
        load(0);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check_beat(0, i, 1'b0);
            step();
        end
        check_idle("restart_end");

        // Magnitude corner bins.
        load(4);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
`ifdef FFT64_BIN_MAG_EN
            if (i == 0) check("mag_min_max", 32'(s_if.out_mag), 32'h0000FFFF);
            if (i == 1) check("mag_m3_p4",   32'(s_if.out_mag), 32'd7);
`else
            if (i < 2) check("mag_off", 32'(s_if.out_mag), 32'd0);
`endif
            check_beat(4, i, 1'b0);
            step();
        end
        check_idle("mag_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft64_bin_streamer.md
# fft64_bin_streamer

Downstream stage of the 64-point DFT. On the DFT's one-cycle `done` pulse it captures the full 8×8 real/imaginary result array into a snapshot buffer. It then streams the 64 bins out one per handshake on a valid/ready interface, with a bin index and a last flag. Because it holds its own copy of the frame, the DFT can start accumulating the next frame while the current one drains.

## Interface
Parameters:
- `W`, 16, bin component width; matches the DFT output width.

Ports:
- `clk`  input  1  single clock; everything is on the rising edge.
- `sreset`  input  1  synchronous, active-high reset.
- `done`  input  1  one-cycle frame-complete pulse from the DFT.
- `realfft`  input  [W-1:0] [0:7][0:7]  real result array, sampled only when `done` is high.
- `imagfft`  input  [W-1:0] [0:7][0:7]  imaginary result array, sampled only when `done` is high.
- `out_valid`  output  1  a bin is presented.
- `out_ready`  input  1  consumer accepts the bin.
- `out_real`  output  W  real part of the presented bin.
- `out_imag`  output  W  imaginary part of the presented bin.
- `out_index`  output  6  bin index, 0..63.
- `out_last`  output  1  high with bin 63.
- `out_mag`  output  W+1  L1 magnitude; see Configuration.
- `busy`  output  1  a frame is held or streaming.
- `overrun`  output  1  one-cycle pulse when a frame is dropped.

## Operation
- **Bin mapping:** bin i corresponds to `realfft[i>>3][i&7]` and `imagfft[i>>3][i&7]`.
- **Snapshot buffer:** 2×64×W registers, written only on a capture.
- **FSM states:** IDLE and STREAM.
- **IDLE:**
  - `out_valid`=0 and `busy`=0.
  - `done`=1 captures the whole array, sets the index to 0, and moves to STREAM.
- **STREAM:**
  - `out_valid`=1 and `busy`=1.
  - Outputs come from the snapshot entry at the current index.
  - A handshake (`out_valid`&`out_ready`) on index < 63 increments the index.
  - A handshake on index 63 returns to IDLE.
- **Stall:** with `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- **Back-to-back frames:** if `done`=1 in the same cycle as the handshake of bin 63:
  - the new array is captured;
  - the index resets to 0;
  - the FSM stays in STREAM;
  - the next frame starts with no bubble cycle.
- **Overrun:** `done`=1 in STREAM at any other time:
  - the new frame is discarded;
  - `overrun` pulses for 1 cycle;
  - the current stream continues unaffected.
- **Data format:**
  - `out_real`/`out_imag` are passed through bit-exact; no scaling.
  - Bins are treated as two's complement only for `out_mag`.
- **Reset:**
  - `sreset`=1 forces IDLE and index 0.
  - Every output goes to 0: `out_valid`, `out_real`, `out_imag`, `out_index`, `out_last`, `out_mag`, `busy`, `overrun`.
  - Reset mid-stream abandons the frame.
  - The snapshot contents need not be cleared.
  - `done` in the reset cycle is ignored.

## Timing
- **Capture latency:** `done` sampled high at edge N gives `out_valid`=1 with bin 0 after edge N, i.e. in cycle N+1.
- **Throughput:** 1 bin per cycle with `out_ready` held high, so a frame drains in 64 consecutive cycles.
- **Output registering:** all outputs are registered or decoded from registered state; there is no combinational path from `out_ready` to any output.
- **`out_last`:** equals (`out_index`==63) & `out_valid`.
- **`overrun`:** asserted in the cycle after the offending `done`.

## Configuration
- **Macro:** `FFT64_BIN_MAG_EN`.
- **Defined:**
  - `out_mag` = |re| + |im|, using two's-complement absolute value extended to W+1 bits.
  - |−2^(W−1)| = 2^(W−1).
  - The maximum is 2^W, which fits without overflow.
  - It is computed at capture time and stored as a 64-entry magnitude array, so it is aligned with `out_real`/`out_imag` at zero extra latency.
- **Undefined:**
  - No magnitude storage or logic is generated.
  - `out_mag` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Basic drain:** load `realfft[r][c]`=8r+c and `imagfft[r][c]`=−(8r+c), pulse `done`, hold `out_ready`=1 → 64 consecutive beats, beat i carries real=i, imag=−i, index=i; `out_last` only on i=63; `busy` falls the cycle after.
- **Backpressure:** toggle `out_ready` pseudo-randomly during a drain → outputs stable while stalled; each bin is delivered exactly once, in order.
- **Back-to-back frames:** pulse `done` with frame B exactly on bin 63's handshake of frame A → bin 0 of B follows with no gap; `overrun` stays 0.
- **Overrun:** pulse `done` while at bin 10 → `overrun` pulses once; the remaining A bins are unchanged; the FSM returns to IDLE after bin 63.
- **Reset mid-stream:** assert `sreset` at bin 30 → all outputs 0 next cycle; the next `done` restarts at index 0.
- **Magnitude (`FFT64_BIN_MAG_EN` defined):**
  - bin with re=0x8000, im=0x7FFF → `out_mag`=0xFFFF.
  - bin with re=−3, im=4 → `out_mag`=7.
  - with the macro undefined, `out_mag`=0 throughout.
